regfile_wb_arb: RTL and testbench

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

---
 rtl/regfile_wb_arb_pkg.sv | 13 +
 rtl/rr_arb2.sv | 14 +
 rtl/regfile_wb_arb.sv | 100 ++++++++++
 tb/tb_regfile_wb_arb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arb_pkg.sv
// Shared definitions for the register-file writeback arbiter: FSM states,
// register-address width and the index of the hardwired zero register.
package regfile_wb_arb_pkg;

  localparam int AW = 5;
  localparam logic [AW-1:0] XZR = 5'd31;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: combinational, prio names the requester that wins a tie.
// No state; the caller owns the priority pointer.
module rr_arb2 (
  input  logic v0,
  input  logic v1,
  input  logic prio,
  output logic g0,
  output logic g1
);

  assign g0 = v0 & (~v1 | ~prio);
  assign g1 = v1 & (~v0 | prio);

endmodule

// File: rtl/regfile_wb_arb.sv
// Arbitrates ALU and load writebacks onto one register-file write port; one cycle latency.
// After reset it clears X0..X30 with readies low, then accepts one request per cycle.
module regfile_wb_arb
  import regfile_wb_arb_pkg::*;
#(
  parameter int N    = 64,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          v0,
  input  logic [AW-1:0] a0,
  input  logic [N-1:0]  d0,
  output logic          rdy0,
  input  logic          v1,
  input  logic [AW-1:0] a1,
  input  logic [N-1:0]  d1,
  output logic          rdy1,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [N-1:0]  wd3,
  output logic          init_done
);

  localparam logic [AW-1:0] KLAST = AW'(NREG - 2);

  state_t        state_q;
  logic [AW-1:0] k_q;
  logic          prio_q;
  logic          we3_q;
  logic [AW-1:0] wa3_q;
  logic [N-1:0]  wd3_q;
  logic          init_done_q;

  logic          g0, g1;
  logic          run;
  logic          wr_d;
  logic [AW-1:0] wa3_d;
  logic [N-1:0]  wd3_d;

  rr_arb2 u_arb (
    .v0  (v0),
    .v1  (v1),
    .prio(prio_q),
    .g0  (g0),
    .g1  (g1)
  );

  assign run  = (state_q == RUN);
  assign rdy0 = run & g0;
  assign rdy1 = run & g1;

  // Accepted writes to the zero register complete the handshake but never reach the port.
  assign wa3_d = rdy1 ? a1 : a0;
  assign wd3_d = rdy1 ? d1 : d0;
  assign wr_d  = (rdy0 | rdy1) & (wa3_d != XZR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CLEAR;
      k_q         <= '0;
      prio_q      <= 1'b0;
      we3_q       <= 1'b0;
      wa3_q       <= '0;
      wd3_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          we3_q <= 1'b1;
          wa3_q <= k_q;
          wd3_q <= '0;
          k_q   <= k_q + AW'(1);
          if (k_q == KLAST) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          we3_q <= wr_d;
          if (wr_d) begin
            wa3_q <= wa3_d;
            wd3_q <= wd3_d;
          end
          // A tie is always accepted in RUN, so the pointer hands the next tie to the loser.
          if (v0 && v1) begin
            prio_q <= ~prio_q;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign we3       = we3_q;
  assign wa3       = wa3_q;
  assign wd3       = wd3_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb: expected writes are queued by the stimulus and
// consumed by a monitor whenever we3 is high; a behavioural register file checks readback.
module tb_regfile_wb_arb;
  import regfile_wb_arb_pkg::*;

  localparam int N    = 64;
  localparam int NREG = 32;

  typedef struct packed {
    logic [4:0]   a;
    logic [N-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic [4:0]    a0 = '0, a1 = '0;
  logic [N-1:0]  d0 = '0, d1 = '0;
  logic          rdy0, rdy1, we3, init_done;
  logic [4:0]    wa3;
  logic [N-1:0]  wd3;

  wr_t           exp_q[$];
  wr_t           e;
  logic [N-1:0]  rf[NREG];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arb #(.N(N), .NREG(NREG)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .v0       (v0),
    .a0       (a0),
    .d0       (d0),
    .rdy0     (rdy0),
    .v1       (v1),
    .a1       (a1),
    .d1       (d1),
    .rdy1     (rdy1),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3),
    .init_done(init_done)
  );

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register file behind the write port; X31 starts at zero and any write to it shows up.
  initial begin
    for (int i = 0; i < NREG; i++) rf[i] = 64'hdead_beef_0000_0000 | N'(i);
    rf[NREG-1] = '0;
  end
  always @(posedge clk) if (we3 === 1'b1) rf[wa3] = wd3;

  always @(negedge clk) begin
    if (reset_n && we3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got wa3=%0d wd3=%0h expected no write", wa3, wd3);
      end else begin
        e = exp_q.pop_front();
        chk("wb_addr", N'(wa3), N'(e.a));
        chk("wb_data", wd3, e.d);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    v0 = 1'b1;
    v1 = 1'b1;
    #1;
    chk({tag, "_we3"}, N'(we3), '0);
    chk({tag, "_wa3"}, N'(wa3), '0);
    chk({tag, "_wd3"}, wd3, '0);
    chk({tag, "_init_done"}, N'(init_done), '0);
    chk({tag, "_rdy0"}, N'(rdy0), '0);
    chk({tag, "_rdy1"}, N'(rdy1), '0);
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  // Called just after reset release; expects X0..X30 cleared on the next 31 edges.
  task automatic clear_seq(input logic drive_v);
    v0 = drive_v;
    v1 = drive_v;
    a0 = 5'd7;
    a1 = 5'd8;
    for (int k = 0; k < NREG - 1; k++) exp_q.push_back(wr_t'{a: 5'(k), d: '0});
    for (int i = 1; i <= NREG - 1; i++) begin
      step();
      if (i <= NREG - 2) begin
        chk("clear_rdy0", N'(rdy0), '0);
        chk("clear_rdy1", N'(rdy1), '0);
        chk("clear_init_done_low", N'(init_done), '0);
      end
      if (i == NREG - 2) begin
        v0 = 1'b0;
        v1 = 1'b0;
      end
    end
    chk("init_done_rise", N'(init_done), 1);
    step();
    chk("init_done_hold", N'(init_done), 1);
  endtask

  // Both requesters hold until their own acceptance; first names the expected winner.
  task automatic dual(input logic first);
    v0 = 1'b1; a0 = 5'd3; d0 = 64'd1;
    v1 = 1'b1; a1 = 5'd4; d1 = 64'd2;
    #1;
    chk("dual_win_rdy0", N'(rdy0), N'(!first));
    chk("dual_win_rdy1", N'(rdy1), N'(first));
    exp_q.push_back(first ? wr_t'{a: 5'd4, d: 64'd2} : wr_t'{a: 5'd3, d: 64'd1});
    step();
    if (first) v1 = 1'b0; else v0 = 1'b0;
    #1;
    chk("dual_lose_rdy", N'(first ? rdy0 : rdy1), 1);
    exp_q.push_back(first ? wr_t'{a: 5'd3, d: 64'd1} : wr_t'{a: 5'd4, d: 64'd2});
    step();
    v0 = 1'b0;
    v1 = 1'b0;
    step();
    step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    step();
    reset_n = 1'b1;
    clear_seq(1'b0);

    // Single ALU write of all-ones, followed by an idle cycle with no write.
    v0 = 1'b1; a0 = 5'd5; d0 = '1;
    #1;
    chk("single_rdy0", N'(rdy0), 1);
    chk("single_rdy1", N'(rdy1), 0);
    exp_q.push_back(wr_t'{a: 5'd5, d: '1});
    step();
    v0 = 1'b0;
    step();
    step();

    dual(1'b0);
    dual(1'b1);

    // Load writeback to XZR: handshake completes, nothing written.
    v1 = 1'b1; a1 = 5'd31; d1 = 64'd7;
    #1;
    chk("xzr_rdy1", N'(rdy1), 1);
    step();
    v1 = 1'b0;
    step();
    step();

    dual(1'b0);

    // Abort the clear sequence at k=10 and restart it.
    reset_n = 1'b0;
    chk_reset_outputs("run_reset");
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) exp_q.push_back(wr_t'{a: 5'(k), d: '0});
    repeat (10) step();
    @(negedge clk);
    #1;
    chk("pre_abort_we3", N'(we3), 1);
    reset_n = 1'b0;
    chk_reset_outputs("clear_reset");
    step();
    reset_n = 1'b1;
    clear_seq(1'b1);

    // Pointer was cleared by reset, so requester 0 wins the next tie again.
    dual(1'b0);

    // Fill X0..X30 with n+1 through alternating requesters at full rate.
    for (int n = 0; n < NREG - 1; n++) begin
      if (n % 2 == 0) begin
        v1 = 1'b0; v0 = 1'b1; a0 = 5'(n); d0 = N'(n + 1);
      end else begin
        v0 = 1'b0; v1 = 1'b1; a1 = 5'(n); d1 = N'(n + 1);
      end
      #1;
      chk("fill_rdy", N'((n % 2 == 0) ? rdy0 : rdy1), 1);
      exp_q.push_back(wr_t'{a: 5'(n), d: N'(n + 1)});
      step();
    end
    v0 = 1'b0;
    v1 = 1'b0;
    step();
    step();
    for (int n = 0; n < NREG; n++) begin
      chk($sformatf("rf_x%0d", n), rf[n], (n < NREG - 1) ? N'(n + 1) : '0);
    end

    chk("pending_writes", N'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
